// File: rtl/i2c_arb_pkg.sv
// -----------------------------------------------------------------------------
// i2c_arb_pkg
// Shared definitions for the I2C master arbiter: FSM state encoding and the
// address/data widths of the i2c_master_controller transaction interface.
// No ports (package).
// -----------------------------------------------------------------------------
package i2c_arb_pkg;

    localparam int   ADDR_W  = 7;
    localparam int   DATA_W  = 8;
    localparam logic RW_READ = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PUSH      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/i2c_master_arbiter_rr.sv
// -----------------------------------------------------------------------------
// i2c_rr_arbiter
// Combinational round-robin picker. The search starts at the requester just
// above ptr_i and wraps modulo NUM_REQ, so the previous owner (ptr_i) has the
// lowest priority.
// Ports:
//   req_i    [NUM_REQ]  request vector
//   ptr_i    [IDX_W]    last owner
//   grant_o  [NUM_REQ]  one-hot winner (all zero when no request)
//   idx_o    [IDX_W]    index of the winner (0 when no request)
//   any_o               at least one request present
// -----------------------------------------------------------------------------
module i2c_rr_arbiter
    import i2c_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        // Offsets 1..NUM_REQ visit every requester once, ending on ptr_i itself.
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = IDX_W'((int'(ptr_i) + off) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/i2c_master_arbiter.sv
// -----------------------------------------------------------------------------
// i2c_master_arbiter
// Shares one i2c_master_controller between NUM_REQ requesters, one transaction
// at a time (the master samples rw_bit live, so nothing may be queued behind
// an active transfer).
//
// Handshakes: a requester holds req_valid and a stable payload until it sees
// its one-cycle req_ready pulse; req_ready coincides with m_start. Completion
// is a one-cycle rsp_valid pulse to the owner, qualified by rsp_err/rsp_data.
//
// Ports:
//   i2c_clock_in, i2c_reset_in       clock, async active-high reset
//   req_valid/req_rw/req_addr/req_data  per-requester request and payload
//   req_ready                         accept pulse to the winner
//   rsp_valid/rsp_err/rsp_data        registered response to the owner
//   grant_id, busy                    current/last owner, not-idle flag
//   m_start/m_rw_bit/m_addr/m_data    to the master
//   m_fifo_full/m_ready/m_data_rd     from the master
// -----------------------------------------------------------------------------
module i2c_master_arbiter
    import i2c_arb_pkg::*;
#(
    parameter  int NUM_REQ       = 4,
    parameter  int START_TIMEOUT = 64,
    parameter  int DONE_TIMEOUT  = 4096,
    localparam int IDX_W         = $clog2(NUM_REQ),
    localparam int TMR_W         = $clog2(DONE_TIMEOUT)
) (
    input  logic                      i2c_clock_in,
    input  logic                      i2c_reset_in,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_rw,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic                      rsp_err,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      busy,
    output logic                      m_start,
    output logic                      m_rw_bit,
    output logic [ADDR_W-1:0]         m_addr,
    output logic [DATA_W-1:0]         m_data,
    input  logic                      m_fifo_full,
    input  logic                      m_ready,
    input  logic [DATA_W-1:0]         m_data_rd
);

    localparam logic [TMR_W-1:0]   TMR_MAX   = {TMR_W{1'b1}};
    localparam logic [TMR_W-1:0]   START_LIM = TMR_W'(START_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]   DONE_LIM  = TMR_W'(DONE_TIMEOUT - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

    logic [NUM_REQ-1:0]  win_onehot;
    logic [IDX_W-1:0]    win_idx;
    logic                win_any;
    logic                win_rw;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;
    logic [NUM_REQ-1:0]  owner_mask;

    i2c_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (win_onehot),
        .idx_o   (win_idx),
        .any_o   (win_any)
    );

    // One-hot payload mux for the current winner.
    always_comb begin
        win_rw   = 1'b0;
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_onehot[i]) begin
                win_rw   = req_rw[i];
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign owner_mask = ONE_HOT0 << grant_q;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        data_d      = data_q;
        // Saturating so a long wait can never wrap back below a limit.
        timer_d     = (timer_q == TMR_MAX) ? timer_q : timer_q + 1'b1;
        rsp_valid_d = '0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = '0;

        case (state_q)
            IDLE: begin
                if (win_any && m_ready && !m_fifo_full) begin
                    grant_d = win_idx;
                    rw_d    = win_rw;
                    addr_d  = win_addr;
                    data_d  = win_data;
                    state_d = PUSH;
                end
            end
            PUSH: begin
                timer_d = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // The master dropping ready is the proof it took the command.
                if (!m_ready) begin
                    timer_d = '0;
                    state_d = WAIT_DONE;
                end else if (timer_q == START_LIM) begin
                    rsp_valid_d = owner_mask;
                    rsp_err_d   = 1'b1;
                    rr_ptr_d    = grant_q;
                    state_d     = IDLE;
                end
            end
            WAIT_DONE: begin
                if (m_ready) begin
                    rsp_valid_d = owner_mask;
                    rsp_data_d  = (rw_q == RW_READ) ? m_data_rd : '0;
                    rr_ptr_d    = grant_q;
                    state_d     = IDLE;
                end else if (timer_q == DONE_LIM) begin
                    rsp_valid_d = owner_mask;
                    rsp_err_d   = 1'b1;
                    rr_ptr_d    = grant_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i2c_clock_in or posedge i2c_reset_in) begin
        if (i2c_reset_in) begin
            state_q     <= IDLE;
            rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
            grant_q     <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            timer_q     <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            timer_q     <= timer_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign req_ready = (state_q == PUSH) ? owner_mask : '0;
    assign m_start   = (state_q == PUSH);
    assign busy      = (state_q != IDLE);
    assign grant_id  = grant_q;
    assign m_rw_bit  = rw_q;
    assign m_addr    = addr_q;
    assign m_data    = data_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_i2c_master_arbiter
// Drives requesters and a behavioural model of the I2C master's ready/FIFO
// signals; expected transactions and responses are queued when requests are
// driven and compared when the arbiter issues m_start / rsp_valid.
// -----------------------------------------------------------------------------
module tb_i2c_master_arbiter;

    localparam int NUM_REQ       = 4;
    localparam int START_TIMEOUT = 64;
    localparam int DONE_TIMEOUT  = 4096;
    localparam int BUDGET        = 6000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_rw    = '0;
    logic [27:0] req_addr  = '0;
    logic [31:0] req_data  = '0;
    logic [3:0]  req_ready, rsp_valid;
    logic        rsp_err;
    logic [7:0]  rsp_data;
    logic [1:0]  grant_id;
    logic        busy, m_start, m_rw_bit;
    logic [6:0]  m_addr;
    logic [7:0]  m_data;
    logic        m_fifo_full = 1'b0;
    logic        m_ready     = 1'b1;
    logic [7:0]  m_data_rd   = '0;

    i2c_master_arbiter #(
        .NUM_REQ(NUM_REQ), .START_TIMEOUT(START_TIMEOUT), .DONE_TIMEOUT(DONE_TIMEOUT)
    ) dut (
        .i2c_clock_in (clk),
        .i2c_reset_in (rst),
        .req_valid    (req_valid),
        .req_rw       (req_rw),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .rsp_data     (rsp_data),
        .grant_id     (grant_id),
        .busy         (busy),
        .m_start      (m_start),
        .m_rw_bit     (m_rw_bit),
        .m_addr       (m_addr),
        .m_data       (m_data),
        .m_fifo_full  (m_fifo_full),
        .m_ready      (m_ready),
        .m_data_rd    (m_data_rd)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] outs();
        logic [63:0] o;
        o = {req_ready, rsp_valid, rsp_err, rsp_data, grant_id, busy,
             m_start, m_rw_bit, m_addr, m_data};
        return o;
    endfunction

    // ---------------- scoreboard ----------------
    // start entry: {idx[1:0], rw, addr[6:0], data[7:0]}
    // rsp entry:   {idx[1:0], err, data[7:0]}
    logic [17:0] exp_start_q[$];
    logic [10:0] exp_rsp_q[$];
    logic [17:0] es;
    logic [10:0] er;
    logic        inflight = 1'b0;
    logic        hold_bad = 1'b0;
    logic [15:0] hold_val = '0;
    int          start_cyc = 0;
    int          rsp_cyc   = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (m_start) begin
                check("start_overlap", inflight, 0);
                inflight  = 1'b1;
                hold_bad  = 1'b0;
                hold_val  = {m_rw_bit, m_addr, m_data};
                start_cyc = cyc;
                if (exp_start_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL start_unexpected: got m_start req_ready=%0h required none", req_ready);
                end else begin
                    es = exp_start_q.pop_front();
                    check("start_txn", {req_ready, grant_id, m_rw_bit, m_addr, m_data},
                          {4'b0001 << es[17:16], es});
                end
            end else if (inflight && ({m_rw_bit, m_addr, m_data} !== hold_val)) begin
                hold_bad = 1'b1;
            end
            if (rsp_valid != 0) begin
                rsp_cyc = cyc;
                check("payload_hold", hold_bad, 0);
                if (exp_rsp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_unexpected: got rsp_valid=%0h required none", rsp_valid);
                end else begin
                    er = exp_rsp_q.pop_front();
                    check("rsp", {rsp_valid, rsp_err, rsp_data}, {4'b0001 << er[10:9], er[8:0]});
                end
                inflight = 1'b0;
            end
        end
    end

    // ---------------- master model ----------------
    int         cfg_drop = 3;
    int         cfg_busy = 40;
    logic [7:0] cfg_rd   = '0;
    logic       cfg_hang = 1'b0;
    int         mphase   = 0;
    int         mcnt     = 0;

    always @(negedge clk) begin
        if (rst) begin
            mphase  = 0;
            mcnt    = 0;
            m_ready = 1'b1;
        end else begin
            case (mphase)
                0: if (m_start) begin
                    mcnt   = cfg_drop;
                    mphase = cfg_hang ? 3 : 1;
                end
                1: if (mcnt <= 1) begin
                    m_ready = 1'b0;
                    mcnt    = cfg_busy;
                    mphase  = 2;
                end else mcnt--;
                2: if (mcnt <= 1) begin
                    m_ready   = 1'b1;
                    m_data_rd = cfg_rd;
                    mphase    = 0;
                end else mcnt--;
                default: if (rsp_valid != 0) mphase = 0;
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_req(input int id, input logic rw, input logic [6:0] a,
                             input logic [7:0] d, input logic err, input logic [7:0] exp_rd);
        req_rw[id]          = rw;
        req_addr[id*7 +: 7] = a;
        req_data[id*8 +: 8] = d;
        req_valid[id]       = 1'b1;
        exp_start_q.push_back({2'(id), rw, a, d});
        exp_rsp_q.push_back({2'(id), err, exp_rd});
    endtask

    task automatic wait_ack(output int id);
        id = -1;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (req_ready != 0) begin
                for (int k = 0; k < NUM_REQ; k++) if (req_ready[k]) id = k;
                req_valid[id] = 1'b0;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL ack_timeout: got no req_ready required one within %0d cycles", BUDGET);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (exp_rsp_q.size() == 0 && !busy) return;
        end
        checks++; errors++;
        $display("FAIL idle_timeout: got %0d pending responses required 0", exp_rsp_q.size());
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int         id;
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
        logic [7:0] rd;
        int         drop;
        int         busy_len;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int   got;
        logic bp_bad;

        vecs[0] = '{0, 1'b0, 7'h50, 8'hA5, 8'h00, 3, 40, 8'h00};
        vecs[1] = '{2, 1'b1, 7'h3C, 8'h00, 8'h5A, 3, 40, 8'h5A};
        vecs[2] = '{1, 1'b1, 7'h7F, 8'hFF, 8'hC3, 1, 5,  8'hC3};
        vecs[3] = '{0, 1'b0, 7'h00, 8'h00, 8'h77, 2, 1,  8'h00};
        vecs[4] = '{2, 1'b0, 7'h2A, 8'h5C, 8'hFF, 1, 12, 8'h00};
        vecs[5] = '{3, 1'b1, 7'h01, 8'h80, 8'hFF, 4, 25, 8'hFF};

        // Reset
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs(), 0);
        rst = 1'b0;

        // Table-driven single transactions
        for (int v = 0; v < 6; v++) begin
            cfg_drop = vecs[v].drop;
            cfg_busy = vecs[v].busy_len;
            cfg_rd   = vecs[v].rd;
            drive_req(vecs[v].id, vecs[v].rw, vecs[v].addr, vecs[v].data, 1'b0, vecs[v].exp_data);
            wait_ack(got);
            check("vec_ack_id", got, vecs[v].id);
            wait_idle();
        end

        // Round-robin: last owner was 3, so order is 0,1,2,3 then re-asserted 0
        cfg_drop = 2; cfg_busy = 10; cfg_rd = 8'h99;
        drive_req(0, 1'b0, 7'h10, 8'h01, 1'b0, 8'h00);
        drive_req(1, 1'b1, 7'h11, 8'h02, 1'b0, 8'h99);
        drive_req(2, 1'b0, 7'h12, 8'h03, 1'b0, 8'h00);
        drive_req(3, 1'b1, 7'h13, 8'h04, 1'b0, 8'h99);
        for (int k = 0; k < 5; k++) begin
            wait_ack(got);
            check("rr_order", got, k % 4);
            if (k == 0) drive_req(0, 1'b1, 7'h14, 8'h05, 1'b0, 8'h99);
        end
        wait_idle();

        // Start timeout: master never drops ready; read data must be zeroed
        cfg_hang = 1'b1;
        drive_req(2, 1'b1, 7'h21, 8'h22, 1'b1, 8'h00);
        wait_ack(got);
        check("to_ack_id", got, 2);
        wait_idle();
        check("start_timeout_latency", rsp_cyc - start_cyc, START_TIMEOUT + 1);
        cfg_hang = 1'b0; cfg_drop = 2; cfg_busy = 6; cfg_rd = 8'h3E;
        drive_req(3, 1'b1, 7'h31, 8'h00, 1'b0, 8'h3E);
        wait_ack(got);
        check("after_to_ack_id", got, 3);
        wait_idle();

        // Back-pressure: FIFO full blocks grants
        @(negedge clk);
        m_fifo_full = 1'b1;
        drive_req(1, 1'b0, 7'h0B, 8'hB0, 1'b0, 8'h00);
        bp_bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (m_start || (req_ready != 0)) bp_bad = 1'b1;
        end
        check("bp_no_grant", bp_bad, 0);
        m_fifo_full = 1'b0;
        @(negedge clk);
        check("bp_grant_latency", {m_start, req_ready}, 5'b1_0010);
        req_valid[1] = 1'b0;
        wait_idle();

        // Reset during WAIT_DONE; last completed owner is 1, so without reset
        // requester 2 would win next.
        cfg_drop = 2; cfg_busy = 300;
        drive_req(3, 1'b0, 7'h33, 8'h44, 1'b0, 8'h00);
        wait_ack(got);
        check("rst_pre_ack", got, 3);
        repeat (10) @(negedge clk);
        check("rst_pre_wait_done", {busy, m_ready}, 2'b10);
        #3 rst = 1'b1;
        #1 check("async_reset_outputs", outs(), 0);
        exp_start_q.delete();
        exp_rsp_q.delete();
        inflight = 1'b0;
        cfg_busy = 8; cfg_rd = 8'h6D;
        drive_req(0, 1'b0, 7'h05, 8'h50, 1'b0, 8'h00);
        drive_req(2, 1'b1, 7'h22, 8'h00, 1'b0, 8'h6D);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_ack(got);
        check("post_reset_first", got, 0);
        wait_ack(got);
        check("post_reset_second", got, 2);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_watchdog: got no completion required finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
